// File: rtl/io_dev_regs.sv
// io_dev_regs: memory-mapped keyboard/display register block (KBDR, KBSR,
// DDR, DSR) sitting behind the address-control decoder. Merges I/O and
// memory read data and ready for the MDR input path.
module io_dev_regs #(
  parameter int DISP_DELAY = 4,
  parameter int CHAR_W     = 8
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              MIO_EN,
  input  logic [1:0]        INMUX_SEL,
  input  logic              LD_KBSR,
  input  logic              LD_DDR,
  input  logic              LD_DSR,
  input  logic [15:0]       MDR_OUT,
  input  logic [15:0]       MEM_OUT,
  input  logic              MEM_R,
  input  logic              i_Kbd_Valid,
  input  logic [CHAR_W-1:0] i_Kbd_Data,
  output logic              o_Disp_Valid,
  input  logic              i_Disp_Ready,
  output logic [CHAR_W-1:0] o_Disp_Data,
  output logic [15:0]       o_MDR_IN,
  output logic              o_R,
  output logic              o_Kbd_Int,
  output logic              o_Disp_Int
);

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_SEND,
    DISP_HOLD
  } disp_state_t;

  disp_state_t       disp_state;
  logic [7:0]        disp_cnt;
  logic [CHAR_W-1:0] kbdr;
  logic [CHAR_W-1:0] ddr;
  logic              kbsr_rdy, kbsr_ie, kbsr_ovr;
  logic              dsr_rdy, dsr_ie, dsr_ovr;
  logic              acc_busy;
  logic              io_r;

  logic              any_ld;
  logic              io_acc;
  logic              first;
  logic              rd_kbdr;
  logic              wr_kbsr;
  logic              wr_ddr;
  logic              wr_dsr;
  logic [15:0]       kbsr_word;
  logic [15:0]       dsr_word;
  logic              unused_mdr;

  // Only bits 15:13 of the status registers and the low character bits of
  // DDR are storage; the remaining write-data bits are intentionally ignored.
  assign unused_mdr = ^MDR_OUT;

  assign any_ld  = LD_KBSR | LD_DDR | LD_DSR;
  assign io_acc  = MIO_EN & ((INMUX_SEL != 2'b11) | any_ld);
  assign first   = io_acc & ~acc_busy;
  assign rd_kbdr = first & (INMUX_SEL == 2'b00) & ~any_ld;
  assign wr_kbsr = first & LD_KBSR;
  assign wr_ddr  = first & LD_DDR;
  assign wr_dsr  = first & LD_DSR;

  assign kbsr_word   = {kbsr_rdy, kbsr_ie, kbsr_ovr, 13'b0};
  assign dsr_word    = {dsr_rdy, dsr_ie, dsr_ovr, 13'b0};
  assign o_Disp_Data = ddr;
  assign o_Kbd_Int   = kbsr_rdy & kbsr_ie;
  assign o_Disp_Int  = dsr_rdy & dsr_ie;
  assign o_R         = io_acc ? io_r : MEM_R;

  // Read data mux toward the MDR input
  always_comb begin
    o_MDR_IN = '0;
    case (INMUX_SEL)
      2'b00:   o_MDR_IN = 16'(kbdr);
      2'b01:   o_MDR_IN = kbsr_word;
      2'b10:   o_MDR_IN = dsr_word;
      default: o_MDR_IN = MEM_OUT;
    endcase
  end

  // Access tracking: side effects once per access, ready one cycle later
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      acc_busy <= 1'b0;
      io_r     <= 1'b0;
    end else if (!MIO_EN) begin
      acc_busy <= 1'b0;
      io_r     <= 1'b0;
    end else begin
      if (io_acc) acc_busy <= 1'b1;
      if (first)  io_r     <= 1'b1;
    end
  end

  // Keyboard capture, read-clear, overrun and KBSR writes
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      kbdr     <= '0;
      kbsr_rdy <= 1'b0;
      kbsr_ie  <= 1'b0;
      kbsr_ovr <= 1'b0;
    end else begin
      if (wr_kbsr) begin
        kbsr_ie <= MDR_OUT[14];
        if (!MDR_OUT[13]) kbsr_ovr <= 1'b0;
      end
      // A read-clear in the same cycle frees the buffer for the new byte,
      // so the capture wins and no overrun is recorded.
      if (i_Kbd_Valid) begin
        if (!kbsr_rdy || rd_kbdr) begin
          kbdr     <= i_Kbd_Data;
          kbsr_rdy <= 1'b1;
        end else begin
          kbsr_ovr <= 1'b1;
        end
      end else if (rd_kbdr) begin
        kbsr_rdy <= 1'b0;
      end
    end
  end

  // Display FSM: load DDR, present byte until accepted, then hold DSR busy
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      disp_state   <= DISP_IDLE;
      disp_cnt     <= '0;
      ddr          <= '0;
      dsr_rdy      <= 1'b1;
      dsr_ie       <= 1'b0;
      dsr_ovr      <= 1'b0;
      o_Disp_Valid <= 1'b0;
    end else begin
      if (wr_dsr) begin
        dsr_ie  <= MDR_OUT[14];
        dsr_ovr <= MDR_OUT[13];
      end
      if (wr_ddr && disp_state != DISP_IDLE) dsr_ovr <= 1'b1;
      case (disp_state)
        DISP_IDLE: begin
          if (wr_ddr) begin
            ddr          <= MDR_OUT[CHAR_W-1:0];
            dsr_rdy      <= 1'b0;
            o_Disp_Valid <= 1'b1;
            disp_state   <= DISP_SEND;
          end
        end
        DISP_SEND: begin
          if (i_Disp_Ready) begin
            o_Disp_Valid <= 1'b0;
            disp_cnt     <= 8'(DISP_DELAY);
            disp_state   <= DISP_HOLD;
          end
        end
        DISP_HOLD: begin
          if (disp_cnt <= 8'd1) begin
            dsr_rdy    <= 1'b1;
            disp_state <= DISP_IDLE;
          end else begin
            disp_cnt <= disp_cnt - 8'd1;
          end
        end
        default: begin
          o_Disp_Valid <= 1'b0;
          disp_state   <= DISP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_dev_regs.sv
// tb_io_dev_regs: directed self-checking bench for io_dev_regs.
module tb_io_dev_regs;

  logic        i_Clk;
  logic        i_Rst_n;
  logic        MIO_EN;
  logic [1:0]  INMUX_SEL;
  logic        LD_KBSR, LD_DDR, LD_DSR;
  logic [15:0] MDR_OUT, MEM_OUT;
  logic        MEM_R;
  logic        i_Kbd_Valid;
  logic [7:0]  i_Kbd_Data;
  logic        o_Disp_Valid;
  logic        i_Disp_Ready;
  logic [7:0]  o_Disp_Data;
  logic [15:0] o_MDR_IN;
  logic        o_R, o_Kbd_Int, o_Disp_Int;

  int checks   = 0;
  int failures = 0;
  logic [15:0] v;

  io_dev_regs #(.DISP_DELAY(4), .CHAR_W(8)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .MIO_EN(MIO_EN), .INMUX_SEL(INMUX_SEL),
    .LD_KBSR(LD_KBSR), .LD_DDR(LD_DDR), .LD_DSR(LD_DSR), .MDR_OUT(MDR_OUT),
    .MEM_OUT(MEM_OUT), .MEM_R(MEM_R), .i_Kbd_Valid(i_Kbd_Valid),
    .i_Kbd_Data(i_Kbd_Data), .o_Disp_Valid(o_Disp_Valid),
    .i_Disp_Ready(i_Disp_Ready), .o_Disp_Data(o_Disp_Data),
    .o_MDR_IN(o_MDR_IN), .o_R(o_R), .o_Kbd_Int(o_Kbd_Int),
    .o_Disp_Int(o_Disp_Int)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // Look at a register through the combinational mux with no access active
  task automatic peek(input logic [1:0] sel, output logic [15:0] val);
    INMUX_SEL = sel;
    #1;
    val = o_MDR_IN;
    INMUX_SEL = 2'b11;
  endtask

  // One complete write access: first edge, then MIO_EN dropped
  task automatic wr_access(input logic ldk, input logic ldd, input logic lds, input logic [15:0] d);
    MIO_EN = 1'b1; INMUX_SEL = 2'b11; LD_KBSR = ldk; LD_DDR = ldd; LD_DSR = lds; MDR_OUT = d;
    step();
    MIO_EN = 1'b0; LD_KBSR = 1'b0; LD_DDR = 1'b0; LD_DSR = 1'b0;
  endtask

  task automatic kbd_strobe(input logic [7:0] d);
    i_Kbd_Valid = 1'b1; i_Kbd_Data = d;
    step();
    i_Kbd_Valid = 1'b0;
  endtask

  initial begin
    i_Rst_n = 1'b0; MIO_EN = 1'b0; INMUX_SEL = 2'b11;
    LD_KBSR = 1'b0; LD_DDR = 1'b0; LD_DSR = 1'b0;
    MDR_OUT = '0; MEM_OUT = '0; MEM_R = 1'b0;
    i_Kbd_Valid = 1'b0; i_Kbd_Data = '0; i_Disp_Ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_disp_valid", 16'(o_Disp_Valid), 16'h0);
    chk("rst_r", 16'(o_R), 16'h0);
    chk("rst_kbd_int", 16'(o_Kbd_Int), 16'h0);
    chk("rst_disp_int", 16'(o_Disp_Int), 16'h0);
    i_Rst_n = 1'b1;
    step();

    // 1. DSR/KBSR read paths and one-cycle I/O ready
    MIO_EN = 1'b1; INMUX_SEL = 2'b10;
    #1;
    chk("t1_dsr_rd", o_MDR_IN, 16'h8000);
    chk("t1_r_first", 16'(o_R), 16'h0);
    step();
    chk("t1_r_next", 16'(o_R), 16'h1);
    INMUX_SEL = 2'b01;
    #1;
    chk("t1_kbsr_rd", o_MDR_IN, 16'h0000);
    MIO_EN = 1'b0; INMUX_SEL = 2'b11;
    step();
    chk("t1_r_idle", 16'(o_R), 16'h0);

    // 2. Keyboard capture, read-clear, clear once per access
    kbd_strobe(8'h41);
    peek(2'b01, v); chk("t2_kbsr_full", v, 16'h8000);
    peek(2'b00, v); chk("t2_kbdr", v, 16'h0041);
    MIO_EN = 1'b1; INMUX_SEL = 2'b00;
    #1;
    chk("t2_rd_data", o_MDR_IN, 16'h0041);
    step();
    INMUX_SEL = 2'b01;
    #1;
    chk("t2_kbsr_cleared", o_MDR_IN, 16'h0000);
    INMUX_SEL = 2'b00;
    i_Kbd_Valid = 1'b1; i_Kbd_Data = 8'h43;
    step();
    i_Kbd_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_r", 16'(o_R), 16'h1);
      step();
    end
    chk("t2_hold_data", o_MDR_IN, 16'h0043);
    MIO_EN = 1'b0; INMUX_SEL = 2'b11;
    step();
    peek(2'b01, v); chk("t2_clear_once", v, 16'h8000);
    MIO_EN = 1'b1; INMUX_SEL = 2'b00;
    step();
    MIO_EN = 1'b0; INMUX_SEL = 2'b11;
    step();
    peek(2'b01, v); chk("t2_kbsr_after_rd", v, 16'h0000);

    // 3. Keyboard overrun and KBSR write
    kbd_strobe(8'h41);
    kbd_strobe(8'h42);
    peek(2'b00, v); chk("t3_kbdr_kept", v, 16'h0041);
    peek(2'b01, v); chk("t3_kbsr_ovr", v, 16'hA000);
    wr_access(1'b1, 1'b0, 1'b0, 16'h4000);
    step();
    peek(2'b01, v); chk("t3_kbsr_wr", v, 16'hC000);
    chk("t3_kbd_int", 16'(o_Kbd_Int), 16'h1);
    wr_access(1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    peek(2'b01, v); chk("t3_kbsr_ie_off", v, 16'h8000);

    // 4. Display send, backpressure, DISP_DELAY hold
    wr_access(1'b0, 1'b1, 1'b0, 16'h0058);
    chk("t4_valid", 16'(o_Disp_Valid), 16'h1);
    chk("t4_data", 16'(o_Disp_Data), 16'h0058);
    peek(2'b10, v); chk("t4_dsr_busy", v, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_stall_valid", 16'(o_Disp_Valid), 16'h1);
      chk("t4_stall_data", 16'(o_Disp_Data), 16'h0058);
    end
    i_Disp_Ready = 1'b1;
    step();
    i_Disp_Ready = 1'b0;
    chk("t4_valid_drop", 16'(o_Disp_Valid), 16'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      peek(2'b10, v); chk("t4_dsr_hold", v, 16'h0000);
    end
    step();
    peek(2'b10, v); chk("t4_dsr_ready", v, 16'h8000);

    // 5. Display overrun during HOLD
    wr_access(1'b0, 1'b1, 1'b0, 16'h0058);
    i_Disp_Ready = 1'b1;
    step();
    i_Disp_Ready = 1'b0;
    wr_access(1'b0, 1'b1, 1'b0, 16'h0059);
    chk("t5_no_valid", 16'(o_Disp_Valid), 16'h0);
    chk("t5_ddr_kept", 16'(o_Disp_Data), 16'h0058);
    step();
    peek(2'b10, v); chk("t5_dsr_ovr_busy", v, 16'h2000);
    step(); step();
    peek(2'b10, v); chk("t5_dsr_ovr_ready", v, 16'hA000);
    step(); step();
    chk("t5_no_second_send", 16'(o_Disp_Valid), 16'h0);
    wr_access(1'b0, 1'b0, 1'b1, 16'h4000);
    step();
    peek(2'b10, v); chk("t5_dsr_wr", v, 16'hC000);
    chk("t5_disp_int", 16'(o_Disp_Int), 16'h1);
    wr_access(1'b0, 1'b0, 1'b1, 16'h0000);
    step();

    // Memory passthrough
    MIO_EN = 1'b1; INMUX_SEL = 2'b11; MEM_OUT = 16'hBEEF; MEM_R = 1'b0;
    #1;
    chk("t5_mem_data", o_MDR_IN, 16'hBEEF);
    chk("t5_mem_r0", 16'(o_R), 16'h0);
    MEM_R = 1'b1;
    #1;
    chk("t5_mem_r1", 16'(o_R), 16'h1);
    step();
    MEM_R = 1'b0;
    #1;
    chk("t5_mem_r_low", 16'(o_R), 16'h0);
    MIO_EN = 1'b0;
    step();
    peek(2'b00, v); chk("t5_mem_kbdr", v, 16'h0041);
    peek(2'b01, v); chk("t5_mem_kbsr", v, 16'h8000);
    peek(2'b10, v); chk("t5_mem_dsr", v, 16'h8000);

    // 6. Simultaneous read-clear and keyboard strobe
    MIO_EN = 1'b1; INMUX_SEL = 2'b00;
    i_Kbd_Valid = 1'b1; i_Kbd_Data = 8'h7A;
    step();
    i_Kbd_Valid = 1'b0; MIO_EN = 1'b0; INMUX_SEL = 2'b11;
    step();
    peek(2'b00, v); chk("t6_kbdr_new", v, 16'h007A);
    peek(2'b01, v); chk("t6_kbsr_full", v, 16'h8000);

    // Reset during SEND
    wr_access(1'b0, 1'b1, 1'b0, 16'h0061);
    chk("t6_send_valid", 16'(o_Disp_Valid), 16'h1);
    i_Rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 16'(o_Disp_Valid), 16'h0);
    peek(2'b10, v); chk("t6_rst_dsr", v, 16'h8000);
    peek(2'b01, v); chk("t6_rst_kbsr", v, 16'h0000);
    step();
    i_Rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
